// File: rtl/lc3_memaccess_ctrl.sv
// LC3 MemAccess sequencer: runs LD/ST/LDI/STI over a fixed-latency data memory port.
// Optional macro LC3_MEMACCESS_STATS_EN adds ld_count/st_count completion counters.
module lc3_memaccess_ctrl #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0] DMem_addr,
  output logic              DMem_rd,
  output logic [DATA_W-1:0] DMem_din,
  input  logic [DATA_W-1:0] DMem_dout,
  output logic [DATA_W-1:0] memout,
  output logic              done
`ifdef LC3_MEMACCESS_STATS_EN
  ,
  output logic [15:0]       ld_count,
  output logic [15:0]       st_count
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 16;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(READ_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IND_RD,
    S_DATA_RD,
    S_DATA_WR,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              st_q, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] memout_q, memout_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_din_q, dmem_din_d;
  logic              dmem_rd_q, dmem_rd_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              rd_hit;

  // Read data is valid on the cycle the wait counter reaches the latency.
  assign rd_hit = (cnt_q == LAT);

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    memout_d    = memout_q;
    dmem_addr_d = dmem_addr_q;
    dmem_din_d  = dmem_din_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          st_d   = req_op[0];
          addr_d = req_addr;
          data_d = req_data;
          cnt_d  = '0;
          if (req_op[1])      state_d = S_IND_RD;
          else if (req_op[0]) state_d = S_DATA_WR;
          else                state_d = S_DATA_RD;
        end
      end
      S_IND_RD: begin
        if (rd_hit) begin
          addr_d  = ADDR_W'(DMem_dout);
          cnt_d   = '0;
          state_d = st_q ? S_DATA_WR : S_DATA_RD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA_RD: begin
        if (rd_hit) begin
          memout_d = DMem_dout;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA_WR: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Port outputs are registered from the state being entered.
    dmem_rd_d = (state_d != S_DATA_WR);
    done_d    = (state_d == S_DONE);
    ready_d   = (state_d == S_IDLE);
    if (state_d == S_IND_RD || state_d == S_DATA_RD || state_d == S_DATA_WR) begin
      dmem_addr_d = addr_d;
    end
    if (state_d == S_DATA_WR) begin
      dmem_din_d = data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      st_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      memout_q    <= '0;
      dmem_addr_q <= '0;
      dmem_din_q  <= '0;
      dmem_rd_q   <= 1'b1;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      memout_q    <= memout_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_din_q  <= dmem_din_d;
      dmem_rd_q   <= dmem_rd_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign DMem_addr = dmem_addr_q;
  assign DMem_rd   = dmem_rd_q;
  assign DMem_din  = dmem_din_q;
  assign memout    = memout_q;
  assign done      = done_q;

`ifdef LC3_MEMACCESS_STATS_EN
  logic [STAT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [STAT_W-1:0] st_cnt_q, st_cnt_d;

  // Completed operations only; an aborted one never reaches DONE.
  always_comb begin
    ld_cnt_d = ld_cnt_q;
    st_cnt_d = st_cnt_q;
    if (state_q == S_DONE) begin
      if (st_q) st_cnt_d = st_cnt_q + STAT_W'(1);
      else      ld_cnt_d = ld_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign ld_count = ld_cnt_q;
  assign st_count = st_cnt_q;
`endif

endmodule

// File: tb/tb_lc3_memaccess_ctrl.sv
// Bench for lc3_memaccess_ctrl: two instances (READ_LAT 1 and 3) against a latency-aware
// memory and a transaction-level reference model.
module tb_lc3_memaccess_ctrl;

  localparam int NINST = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid [NINST];
  logic        req_ready [NINST];
  logic [1:0]  req_op    [NINST];
  logic [15:0] req_addr  [NINST];
  logic [15:0] req_data  [NINST];
  logic [15:0] DMem_addr [NINST];
  logic        DMem_rd   [NINST];
  logic [15:0] DMem_din  [NINST];
  logic [15:0] dmem_dout [NINST];
  logic [15:0] memout    [NINST];
  logic        done      [NINST];
`ifdef LC3_MEMACCESS_STATS_EN
  logic [15:0] ld_count  [NINST];
  logic [15:0] st_count  [NINST];
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  lc3_memaccess_ctrl #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1)) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_addr(req_addr[0]), .req_data(req_data[0]),
    .DMem_addr(DMem_addr[0]), .DMem_rd(DMem_rd[0]), .DMem_din(DMem_din[0]),
    .DMem_dout(dmem_dout[0]), .memout(memout[0]), .done(done[0])
`ifdef LC3_MEMACCESS_STATS_EN
    , .ld_count(ld_count[0]), .st_count(st_count[0])
`endif
  );

  lc3_memaccess_ctrl #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3)) dut1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_addr(req_addr[1]), .req_data(req_data[1]),
    .DMem_addr(DMem_addr[1]), .DMem_rd(DMem_rd[1]), .DMem_din(DMem_din[1]),
    .DMem_dout(dmem_dout[1]), .memout(memout[1]), .done(done[1])
`ifdef LC3_MEMACCESS_STATS_EN
    , .ld_count(ld_count[1]), .st_count(st_count[1])
`endif
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] hash16(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory: unwritten words read as a hash of the address; data only valid once the
  // address has been held for the read latency, otherwise the inverse is returned.
  bit   [15:0] mem_data [NINST][65536];
  bit          mem_vld  [NINST][65536];
  logic [15:0] prev_addr [NINST];
  logic        prev_rd   [NINST];
  int          prev_age  [NINST];
  int          cur_age   [NINST];
  int          wr_cnt    [NINST];
  logic [15:0] last_wa   [NINST];
  logic [15:0] last_wd   [NINST];
  int          cyc = 0;

  always_comb begin
    logic [15:0] mv;
    for (int k = 0; k < NINST; k++) begin
      cur_age[k] = (DMem_rd[k] === 1'b1 && prev_rd[k] === 1'b1 && DMem_addr[k] === prev_addr[k])
                   ? prev_age[k] + 1 : 0;
      mv = mem_vld[k][DMem_addr[k]] ? mem_data[k][DMem_addr[k]] : hash16(DMem_addr[k]);
      dmem_dout[k] = (cur_age[k] >= lat_of(k)) ? mv : ~mv;
    end
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int k = 0; k < NINST; k++) begin
      prev_addr[k] <= DMem_addr[k];
      prev_rd[k]   <= DMem_rd[k];
      prev_age[k]  <= cur_age[k];
      if (DMem_rd[k] === 1'b0) begin
        mem_data[k][DMem_addr[k]] <= DMem_din[k];
        mem_vld[k][DMem_addr[k]]  <= 1'b1;
        wr_cnt[k]  <= wr_cnt[k] + 1;
        last_wa[k] <= DMem_addr[k];
        last_wd[k] <= DMem_din[k];
      end
    end
  end

  // Reference model state
  logic [15:0] ref_mem [int];
  logic [15:0] exp_mo  [NINST];
  logic [15:0] exp_ld  [NINST];
  logic [15:0] exp_st  [NINST];

  function automatic logic [15:0] ref_rd(input int k, input logic [15:0] a);
    int key;
    key = k * 65536 + int'(a);
    return ref_mem.exists(key) ? ref_mem[key] : hash16(a);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NINST; k++) begin
      exp_mo[k] = 16'h0000;
      exp_ld[k] = 16'h0000;
      exp_st[k] = 16'h0000;
    end
  endtask

  task automatic run_op(input int k, input logic [1:0] op, input logic [15:0] addr,
                        input logic [15:0] data, input bit hold);
    int          lat;
    int          exp_edges;
    int          n;
    int          wr0;
    int          rd_low;
    int          rd_at_ptr;
    logic [15:0] ptr;
    lat       = lat_of(k);
    ptr       = op[1] ? ref_rd(k, addr) : addr;
    exp_edges = (op[1] ? lat + 1 : 0) + (op[0] ? 1 : lat + 1);
    if (op[0]) begin
      ref_mem[k * 65536 + int'(ptr)] = data;
      exp_st[k] = exp_st[k] + 16'd1;
    end else begin
      exp_mo[k] = ref_rd(k, ptr);
      exp_ld[k] = exp_ld[k] + 16'd1;
    end

    n = 0;
    while (req_ready[k] !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (req_ready[k] !== 1'b1) begin
      failures++;
      $display("FAIL ready_wait inst=%0d got=%b want=1", k, req_ready[k]);
      return;
    end
    req_valid[k] = 1'b1;
    req_op[k]    = op;
    req_addr[k]  = addr;
    req_data[k]  = data;
    wr0          = wr_cnt[k];
    @(negedge clock);
    if (!hold) req_valid[k] = 1'b0;
    checks++;
    if (req_ready[k] !== 1'b0) begin
      failures++;
      $display("FAIL busy_ready inst=%0d op=%0d got=%b want=0", k, op, req_ready[k]);
    end

    n = 0; rd_low = 0; rd_at_ptr = 0;
    while (done[k] !== 1'b1 && n < 200) begin
      if (DMem_rd[k] === 1'b0) rd_low++;
      if (DMem_rd[k] === 1'b1 && DMem_addr[k] === ptr) rd_at_ptr++;
      @(negedge clock);
      n++;
    end
    checks++;
    if (n != exp_edges) begin
      failures++;
      $display("FAIL latency inst=%0d op=%0d addr=%h got=T+%0d want=T+%0d", k, op, addr, n + 1, exp_edges + 1);
    end
    checks++;
    if (memout[k] !== exp_mo[k]) begin
      failures++;
      $display("FAIL memout inst=%0d op=%0d addr=%h got=%h want=%h", k, op, addr, memout[k], exp_mo[k]);
    end
    if (op[0]) begin
      checks++;
      if (wr_cnt[k] - wr0 != 1 || rd_low != 1 || last_wa[k] !== ptr || last_wd[k] !== data) begin
        failures++;
        $display("FAIL store_write inst=%0d op=%0d got=%0d writes/%0d low cycles @%h=%h want=1/1 @%h=%h",
                 k, op, wr_cnt[k] - wr0, rd_low, last_wa[k], last_wd[k], ptr, data);
      end
    end else begin
      checks++;
      if (wr_cnt[k] - wr0 != 0) begin
        failures++;
        $display("FAIL load_nowrite inst=%0d got=%0d writes want=0", k, wr_cnt[k] - wr0);
      end
      if (op == 2'b00) begin
        checks++;
        if (rd_at_ptr != lat + 1) begin
          failures++;
          $display("FAIL ld_addr_hold inst=%0d got=%0d cycles want=%0d", k, rd_at_ptr, lat + 1);
        end
      end
    end
    @(negedge clock);
    checks++;
    if (done[k] !== 1'b0 || req_ready[k] !== 1'b1) begin
      failures++;
      $display("FAIL done_pulse inst=%0d got done=%b ready=%b want done=0 ready=1", k, done[k], req_ready[k]);
    end
`ifdef LC3_MEMACCESS_STATS_EN
    checks++;
    if (ld_count[k] !== exp_ld[k] || st_count[k] !== exp_st[k]) begin
      failures++;
      $display("FAIL stats inst=%0d got ld=%0d st=%0d want ld=%0d st=%0d",
               k, ld_count[k], st_count[k], exp_ld[k], exp_st[k]);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < NINST; k++) begin
      checks++;
      if (DMem_rd[k] !== 1'b1 || DMem_addr[k] !== 16'h0000 || memout[k] !== 16'h0000 ||
          done[k] !== 1'b0 || req_ready[k] !== 1'b1) begin
        failures++;
        $display("FAIL reset_state inst=%0d got rd=%b addr=%h memout=%h done=%b ready=%b want 1/0000/0000/0/1",
                 k, DMem_rd[k], DMem_addr[k], memout[k], done[k], req_ready[k]);
      end
`ifdef LC3_MEMACCESS_STATS_EN
      checks++;
      if (ld_count[k] !== 16'h0000 || st_count[k] !== 16'h0000) begin
        failures++;
        $display("FAIL reset_stats inst=%0d got ld=%0d st=%0d want 0/0", k, ld_count[k], st_count[k]);
      end
`endif
    end
  endtask

  task automatic test_store_load();
    for (int k = 0; k < NINST; k++) begin
      run_op(k, 2'b01, 16'h3000, 16'hBEEF, 1'b0);
      run_op(k, 2'b00, 16'h3000, 16'h0000, 1'b0);
    end
  endtask

  task automatic test_indirect();
    for (int k = 0; k < NINST; k++) begin
      run_op(k, 2'b01, 16'h3000, 16'h1234, 1'b0);
      run_op(k, 2'b01, 16'h4000, 16'h3000, 1'b0);
      run_op(k, 2'b10, 16'h4000, 16'h0000, 1'b0);
      run_op(k, 2'b01, 16'h4000, 16'h5000, 1'b0);
      run_op(k, 2'b11, 16'h4000, 16'h00FF, 1'b0);
      run_op(k, 2'b00, 16'h5000, 16'h0000, 1'b0);
    end
  endtask

  task automatic test_boundary();
    for (int k = 0; k < NINST; k++) begin
      run_op(k, 2'b01, 16'hFFFF, 16'h0000, 1'b0);
      run_op(k, 2'b01, 16'h0000, 16'hFFFF, 1'b0);
      run_op(k, 2'b10, 16'h0000, 16'h0000, 1'b0);
      run_op(k, 2'b10, 16'hFFFF, 16'h0000, 1'b0);
      run_op(k, 2'b11, 16'hFFFF, 16'hA5A5, 1'b0);
      run_op(k, 2'b00, 16'h0000, 16'h0000, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    run_op(0, 2'b01, 16'h1234, 16'h4321, 1'b1);
    run_op(0, 2'b00, 16'h1234, 16'h0000, 1'b1);
    run_op(0, 2'b10, 16'h0123, 16'h0000, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int          k;
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] d;
      k  = int'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom_range(0, 65535));
      d  = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'hFFFF;
      run_op(k, op, a, d, 1'b0);
    end
  endtask

  task automatic test_abort();
    int wr0;
    int seen_done;
    run_op(0, 2'b01, 16'h6000, 16'h7000, 1'b0);
    run_op(0, 2'b01, 16'h7000, 16'hCAFE, 1'b0);
    run_op(0, 2'b00, 16'h2222, 16'h0000, 1'b0);
    wr0 = wr_cnt[0];
    seen_done = 0;
    req_valid[0] = 1'b1;
    req_op[0]    = 2'b10;
    req_addr[0]  = 16'h6000;
    req_data[0]  = 16'h0000;
    @(negedge clock);
    req_valid[0] = 1'b0;
    reset = 1'b0;
    if (done[0] === 1'b1) seen_done++;
    @(negedge clock);
    reset = 1'b1;
    if (done[0] === 1'b1) seen_done++;
    model_reset();
    @(negedge clock);
    if (done[0] === 1'b1) seen_done++;
    checks++;
    if (seen_done != 0 || wr_cnt[0] - wr0 != 0) begin
      failures++;
      $display("FAIL abort_effects got done_pulses=%0d writes=%0d want 0/0", seen_done, wr_cnt[0] - wr0);
    end
    checks++;
    if (req_ready[0] !== 1'b1 || memout[0] !== exp_mo[0] || DMem_rd[0] !== 1'b1) begin
      failures++;
      $display("FAIL abort_state got ready=%b memout=%h rd=%b want 1/%h/1", req_ready[0], memout[0], DMem_rd[0], exp_mo[0]);
    end
`ifdef LC3_MEMACCESS_STATS_EN
    checks++;
    if (ld_count[0] !== 16'h0000 || st_count[0] !== 16'h0000) begin
      failures++;
      $display("FAIL abort_stats got ld=%0d st=%0d want 0/0", ld_count[0], st_count[0]);
    end
`endif
    run_op(0, 2'b10, 16'h6000, 16'h0000, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    for (int k = 0; k < NINST; k++) begin
      req_valid[k] = 1'b0;
      req_op[k]    = 2'b00;
      req_addr[k]  = 16'h0000;
      req_data[k]  = 16'h0000;
    end
    @(negedge clock);
    test_reset();
    test_store_load();
    test_indirect();
    test_boundary();
    test_back_to_back();
    test_random();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
